// File: rtl/a23_copro15_ext_pkg.sv
// Shared constants and types for the Amber 2 CP15 system-control coprocessor.
package a23_copro15_ext_pkg;

  localparam logic [1:0] OP_MRC = 2'd1;
  localparam logic [1:0] OP_MCR = 2'd2;

  localparam logic [3:0] CRN_ID          = 4'd0;
  localparam logic [3:0] CRN_FLUSH       = 4'd1;
  localparam logic [3:0] CRN_CTRL        = 4'd2;
  localparam logic [3:0] CRN_CACHEABLE   = 4'd3;
  localparam logic [3:0] CRN_UPDATEABLE  = 4'd4;
  localparam logic [3:0] CRN_DISRUPTIVE  = 4'd5;
  localparam logic [3:0] CRN_FAULT_STAT  = 4'd6;
  localparam logic [3:0] CRN_FAULT_ADDR  = 4'd7;
  localparam logic [3:0] CRN_FLUSH_STAT  = 4'd8;

  typedef enum logic {IDLE, FLUSH} flush_state_e;

  typedef struct packed {
    logic [7:0]  status;
    logic [31:0] address;
  } fault_entry_t;

endpackage

// File: rtl/a23_copro15_ext_fault_fifo.sv
// Fault FIFO: read pointer plus occupancy count; write slot is derived from both.
module a23_fault_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = i_pop && !o_empty;
  // A pop on a full FIFO frees the slot the push lands in.
  assign do_push = i_push && (!o_full || do_pop);
  assign wr_ptr  = rd_ptr_q + count_q[AW-1:0];
  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (i_rst) begin
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the count alone decides which entries are valid.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr] <= i_data;
  end

endmodule

// File: rtl/a23_copro15_ext.sv
// CP15 system-control coprocessor: cache control, region maps, fault FIFO and
// a line-by-line cache flush sequencer handshaking with the cache controller.
module a23_copro15_ext
  import a23_copro15_ext_pkg::*;
#(
  parameter int          CACHE_LINES = 256,
  parameter int          FAULT_DEPTH = 4,
  parameter logic [31:0] ID_VALUE    = 32'h4156_0310
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_fetch_stall,
  input  logic [1:0]                     i_copro_operation,
  input  logic [3:0]                     i_copro_crn,
  input  logic [31:0]                    i_copro_write_data,
  input  logic                           i_fault,
  input  logic [7:0]                     i_fault_status,
  input  logic [31:0]                    i_fault_address,
  output logic [31:0]                    o_copro_read_data,
  output logic                           o_cache_enable,
  output logic [31:0]                    o_cacheable_area,
  output logic [31:0]                    o_updateable_area,
  output logic [31:0]                    o_disruptive_area,
  output logic                           o_flush_req,
  output logic [$clog2(CACHE_LINES)-1:0] o_flush_index,
  input  logic                           i_flush_ack,
  output logic                           o_flush_busy
);

  localparam int IW = $clog2(CACHE_LINES);
  localparam int CW = $clog2(FAULT_DEPTH) + 1;

  logic [2:0]   ctrl_q, ctrl_d;
  logic [31:0]  cacheable_q, cacheable_d;
  logic [31:0]  updateable_q, updateable_d;
  logic [31:0]  disruptive_q, disruptive_d;
  logic [31:0]  rd_data_q, rd_data_d;
  logic         ovf_q, ovf_d;
  flush_state_e state_q, state_d;
  logic [IW-1:0] index_q, index_d;
  logic         req_q, req_d;

  logic         mcr, flush_start, fifo_push, fifo_pop;
  fault_entry_t push_entry, head_entry;
  logic [CW-1:0] fifo_count;
  logic         fifo_full, fifo_empty;
  logic [7:0]   head_status;
  logic [31:0]  head_address;

  assign mcr         = (i_copro_operation == OP_MCR) && !i_fetch_stall;
  assign flush_start = mcr && (i_copro_crn == CRN_FLUSH);
  assign fifo_push   = i_fault && !i_fetch_stall;
  assign fifo_pop    = mcr && (i_copro_crn == CRN_FAULT_STAT);
  assign push_entry  = '{status: i_fault_status, address: i_fault_address};

  a23_fault_fifo #(
    .DEPTH (FAULT_DEPTH),
    .WIDTH ($bits(fault_entry_t))
  ) u_fault_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (fifo_push),
    .i_pop   (fifo_pop),
    .i_data  (push_entry),
    .o_head  (head_entry),
    .o_count (fifo_count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign head_status  = fifo_empty ? 8'd0  : head_entry.status;
  assign head_address = fifo_empty ? 32'd0 : head_entry.address;

  always_comb begin
    ctrl_d       = ctrl_q;
    cacheable_d  = cacheable_q;
    updateable_d = updateable_q;
    disruptive_d = disruptive_q;
    ovf_d        = ovf_q;
    if (mcr) begin
      unique case (i_copro_crn)
        CRN_CTRL:       ctrl_d       = i_copro_write_data[2:0];
        CRN_CACHEABLE:  cacheable_d  = i_copro_write_data;
        CRN_UPDATEABLE: updateable_d = i_copro_write_data;
        CRN_DISRUPTIVE: disruptive_d = i_copro_write_data;
        CRN_FAULT_STAT: ovf_d        = 1'b0;
        default: ;
      endcase
    end
    // A pop on a full FIFO makes room, so only an unpaired push is dropped.
    if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (!i_fetch_stall) begin
      unique case (i_copro_crn)
        CRN_ID:         rd_data_d = ID_VALUE;
        CRN_CTRL:       rd_data_d = {29'd0, ctrl_q};
        CRN_CACHEABLE:  rd_data_d = cacheable_q;
        CRN_UPDATEABLE: rd_data_d = updateable_q;
        CRN_DISRUPTIVE: rd_data_d = disruptive_q;
        CRN_FAULT_STAT: rd_data_d = {ovf_q, 7'd0, 8'(fifo_count), 8'd0, head_status};
        CRN_FAULT_ADDR: rd_data_d = head_address;
        CRN_FLUSH_STAT: rd_data_d = {(state_q == FLUSH), 15'd0, 16'(index_q)};
        default:        rd_data_d = 32'd0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    req_d   = req_q;
    unique case (state_q)
      IDLE: begin
        if (flush_start) begin
          state_d = FLUSH;
          index_d = '0;
          req_d   = 1'b1;
        end
      end
      FLUSH: begin
        if (flush_start) begin
          index_d = '0;
        end else if (i_flush_ack) begin
          if (index_q == IW'(CACHE_LINES - 1)) begin
            state_d = IDLE;
            index_d = '0;
            req_d   = 1'b0;
          end else begin
            index_d = index_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        index_d = '0;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ctrl_q       <= '0;
      cacheable_q  <= '0;
      updateable_q <= '0;
      disruptive_q <= '0;
      rd_data_q    <= '0;
      ovf_q        <= 1'b0;
      state_q      <= IDLE;
      index_q      <= '0;
      req_q        <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      cacheable_q  <= cacheable_d;
      updateable_q <= updateable_d;
      disruptive_q <= disruptive_d;
      rd_data_q    <= rd_data_d;
      ovf_q        <= ovf_d;
      state_q      <= state_d;
      index_q      <= index_d;
      req_q        <= req_d;
    end
  end

  assign o_copro_read_data = rd_data_q;
  assign o_flush_busy      = (state_q == FLUSH);
  assign o_cache_enable    = ctrl_q[0] && !o_flush_busy;
  assign o_cacheable_area  = cacheable_q;
  assign o_updateable_area = updateable_q;
  assign o_disruptive_area = disruptive_q;
  assign o_flush_req       = req_q;
  assign o_flush_index     = index_q;

endmodule

// File: tb/tb_a23_copro15_ext.sv
// Bench for a23_copro15_ext: directed scenarios then random traffic, all against a queue-based model.
module tb_a23_copro15_ext;

  localparam int          L  = 8;
  localparam int          D  = 4;
  localparam logic [31:0] ID = 32'h4156_0310;

  logic        clk = 1'b0;
  logic        rst, stall, fault, ack;
  logic [1:0]  op;
  logic [3:0]  crn;
  logic [31:0] wdata, fad;
  logic [7:0]  fst;

  logic [31:0] rd_data, cacheable, updateable, disruptive;
  logic        cache_en, flush_req, flush_busy;
  logic [2:0]  flush_index;

  a23_copro15_ext #(
    .CACHE_LINES (L),
    .FAULT_DEPTH (D),
    .ID_VALUE    (ID)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_fetch_stall      (stall),
    .i_copro_operation  (op),
    .i_copro_crn        (crn),
    .i_copro_write_data (wdata),
    .i_fault            (fault),
    .i_fault_status     (fst),
    .i_fault_address    (fad),
    .o_copro_read_data  (rd_data),
    .o_cache_enable     (cache_en),
    .o_cacheable_area   (cacheable),
    .o_updateable_area  (updateable),
    .o_disruptive_area  (disruptive),
    .o_flush_req        (flush_req),
    .o_flush_index      (flush_index),
    .i_flush_ack        (ack),
    .o_flush_busy       (flush_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: register values, a queue of faults, flush as busy flag + line number.
  bit [2:0]  m_ctrl;
  bit [31:0] m_area [3];
  bit [39:0] m_q [$];
  bit        m_ovf, m_busy;
  int        m_idx;
  bit [31:0] m_rd;

  function automatic bit [31:0] m_read(input int c);
    bit [39:0] h;
    h = (m_q.size() > 0) ? m_q[0] : 40'd0;
    case (c)
      0:       return ID;
      2:       return {29'd0, m_ctrl};
      3, 4, 5: return m_area[c-3];
      6:       return {m_ovf, 7'd0, 8'(m_q.size()), 8'd0, h[39:32]};
      7:       return h[31:0];
      8:       return {m_busy, 15'd0, 16'(m_idx)};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    bit mcr, popped;
    int size_before;
    if (rst) begin
      m_ctrl = 0; m_area = '{default: 0}; m_q.delete();
      m_ovf = 0; m_busy = 0; m_idx = 0; m_rd = 0;
      return;
    end
    mcr = (op == 2'd2) && !stall;
    popped = 0;
    size_before = m_q.size();
    if (!stall) m_rd = m_read(int'(crn));
    if (mcr && crn == 4'd6) begin
      if (size_before > 0) begin m_q.delete(0); popped = 1; end
      m_ovf = 0;
    end
    if (fault && !stall) begin
      if (size_before == D && !popped) m_ovf = 1;
      else m_q.push_back({fst, fad});
    end
    if (mcr && crn == 4'd1) begin
      m_busy = 1; m_idx = 0;
    end else if (m_busy && ack) begin
      if (m_idx == L - 1) begin m_busy = 0; m_idx = 0; end
      else m_idx++;
    end
    if (mcr && crn == 4'd2) m_ctrl = wdata[2:0];
    if (mcr && crn >= 4'd3 && crn <= 4'd5) m_area[int'(crn)-3] = wdata;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("rd_data",    rd_data,            m_rd);
    check("cache_en",   32'(cache_en),      32'(m_ctrl[0] & ~m_busy));
    check("cacheable",  cacheable,          m_area[0]);
    check("updateable", updateable,         m_area[1]);
    check("disruptive", disruptive,         m_area[2]);
    check("flush_req",  32'(flush_req),     32'(m_busy));
    check("flush_busy", 32'(flush_busy),    32'(m_busy));
    check("flush_idx",  32'(flush_index),   32'(m_idx));
  endtask

  task automatic set_idle();
    rst = 0; stall = 0; op = 0; crn = 0; wdata = 0;
    fault = 0; fst = 0; fad = 0; ack = 0;
  endtask

  task automatic mrc(input logic [3:0] c);
    set_idle(); op = 2'd1; crn = c; tick();
  endtask

  task automatic mcr(input logic [3:0] c, input logic [31:0] d);
    set_idle(); op = 2'd2; crn = c; wdata = d; tick();
  endtask

  initial begin
    int n;
    set_idle();
    rst = 1; tick(); tick();
    check("reset_rd", rd_data, 32'd0);

    mrc(4'd0); check("id_read", rd_data, 32'h4156_0310);
    mrc(4'd2); check("ctrl_reset", rd_data, 32'd0);
    check("cache_en_reset", 32'(cache_en), 32'd0);
    check("flush_req_reset", 32'(flush_req), 32'd0);

    mcr(4'd3, 32'hA5A5_0001);
    mrc(4'd3); check("area3_write", rd_data, 32'hA5A5_0001);
    set_idle(); op = 2'd2; crn = 4'd3; wdata = 32'hDEAD_BEEF; stall = 1; tick();
    mrc(4'd3); check("area3_stalled_write", rd_data, 32'hA5A5_0001);

    for (int i = 1; i <= 5; i++) begin
      set_idle(); fault = 1; fst = 8'(i); fad = 32'(i * 256); tick();
    end
    mrc(4'd6); check("fifo_overflow_stat", rd_data, 32'h8004_0001);
    mrc(4'd7); check("fifo_head_addr", rd_data, 32'h0000_0100);
    mcr(4'd6, 32'd0);
    mrc(4'd6); check("fifo_after_pop", rd_data, 32'h0003_0002);

    set_idle(); fault = 1; fst = 8'd6; fad = 32'h600; tick();
    set_idle(); op = 2'd2; crn = 4'd6; fault = 1; fst = 8'd7; fad = 32'h700; tick();
    mrc(4'd6); check("fifo_full_pop_push", rd_data, 32'h0004_0003);

    mcr(4'd2, 32'd1);
    check("cache_en_on", 32'(cache_en), 32'd1);

    // Flush with ack held high.
    set_idle(); op = 2'd2; crn = 4'd1; ack = 1; tick();
    check("flush_busy_rise", 32'(flush_busy), 32'd1);
    check("cache_en_in_flush", 32'(cache_en), 32'd0);
    set_idle(); ack = 1; n = 0;
    while (flush_busy && n < 40) begin
      check("walk_idx", 32'(flush_index), 32'(n));
      tick(); n++;
    end
    check("flush_len_ack_held", 32'(n), 32'd8);

    // Flush with ack on every other cycle, starting low.
    mcr(4'd1, 32'd0);
    n = 0;
    while (flush_busy && n < 60) begin
      set_idle(); ack = logic'(n % 2);
      check("walk_idx_half", 32'(flush_index), 32'(n / 2));
      tick(); n++;
    end
    check("flush_len_ack_half", 32'(n), 32'd16);

    // Restart on an ack at index 5, then reset at index 3.
    mcr(4'd1, 32'd0);
    n = 0;
    while (flush_index != 3'd5 && n < 20) begin set_idle(); ack = 1; tick(); n++; end
    set_idle(); op = 2'd2; crn = 4'd1; ack = 1; tick();
    check("restart_idx", 32'(flush_index), 32'd0);
    check("restart_busy", 32'(flush_busy), 32'd1);
    n = 0;
    while (flush_index != 3'd3 && n < 20) begin set_idle(); ack = 1; tick(); n++; end
    set_idle(); rst = 1; ack = 1; tick();
    check("rst_req", 32'(flush_req), 32'd0);
    check("rst_idx", 32'(flush_index), 32'd0);
    mrc(4'd6); check("rst_fifo_clear", rd_data, 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 499) == 0);
      stall = ($urandom_range(0, 7) == 0);
      op    = 2'($urandom_range(0, 2));
      crn   = 4'($urandom_range(0, 9));
      wdata = $urandom;
      fault = ($urandom_range(0, 3) == 0);
      fst   = 8'($urandom);
      fad   = $urandom;
      ack   = 1'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/a23_copro15_ext.md
# a23_copro15_ext

Parametrised CP15 system-control coprocessor for the Amber 2 core, successor to the single-entry CP15 register block. It holds the cache control and 2 MB region maps, keeps a FIFO of access faults rather than a single latched fault, and runs a line-by-line cache flush sequencer with a handshake to the cache. It sits beside the execute stage, on the same MCR/MRC operation bus, and drives the cache controller.

## Interface
Parameters:
- CACHE_LINES, 256: lines walked per flush; power of 2, 2..1024.
- FAULT_DEPTH, 4: fault FIFO entries; power of 2, 2..16.
- ID_VALUE, 32'h4156_0310: value returned by the crn 0 read.

Ports:
- i_clk  in  1  sole clock.
- i_rst  in  1  reset: synchronous, active-high.
- i_fetch_stall  in  1  freezes register writes, reads, fault capture and FIFO pops; does not freeze the flush FSM.
- i_copro_operation  in  2  2 = MCR write, 1 = MRC read, other = none.
- i_copro_crn  in  4  register number.
- i_copro_write_data  in  32  MCR data.
- i_fault  in  1  push a fault entry.
- i_fault_status  in  8  status to push.
- i_fault_address  in  32  address to push.
- o_copro_read_data  out  32  registered MRC data.
- o_cache_enable  out  1  cache_control[0] AND NOT flush busy.
- o_cacheable_area / o_updateable_area / o_disruptive_area  out  32 each  region maps.
- o_flush_req  out  1  flush request for line o_flush_index.
- o_flush_index  out  log2(CACHE_LINES)  line being flushed.
- i_flush_ack  in  1  cache has invalidated the current line.
- o_flush_busy  out  1  high in state FLUSH.

## Operation
- Reset: all region maps 0, cache_control 0, FIFO empty, overflow flag 0, FSM in IDLE, o_copro_read_data 0, o_flush_req 0, o_flush_index 0.
- MCR (op 2, stall low):
  - crn 2: cache_control <= data[2:0].
  - crn 3, 4, 5: cacheable, updateable, disruptive area <= data.
  - crn 1: start a flush. In FLUSH this restarts the walk at index 0.
  - crn 6: pop the FIFO head. Ignored when the FIFO is empty. Also clears the overflow flag.
  - Any other crn: no effect.
- MRC data is loaded every non-stalled cycle from i_copro_crn:
  - 0: ID_VALUE.
  - 2: {29'd0, cache_control}.
  - 3–5: the area registers.
  - 6: {overflow, 7'd0, count[7:0], 8'd0, head_status}. head_status reads 0 when the FIFO is empty.
  - 7: head_address, or 0 when empty.
  - 8: {flush_busy, 15'd0, zero-extended flush_index}.
  - Others: 0.
- Fault FIFO:
  - i_fault with stall low pushes {status, address}.
  - When full with no pop in the same cycle, the new entry is dropped and overflow is set (sticky).
  - Push and pop in the same cycle when not empty: both occur, count unchanged.
  - Push and pop in the same cycle when empty: the pop is ignored and the push is taken.
- Flush FSM:
  - IDLE: on MCR crn 1, go to FLUSH with index 0.
  - FLUSH: o_flush_req is held high. Each cycle with i_flush_ack high, index increments.
  - An ack at index CACHE_LINES−1 returns the FSM to IDLE; index wraps to 0 and req falls the next cycle.
  - MCR crn 1 in the same cycle as an ack: the restart wins, and the index is 0 next cycle.
  - An MCR crn 2 during FLUSH updates cache_control; o_cache_enable stays low until IDLE.

## Timing
- MCR write is visible on the outputs the cycle after the write cycle.
- MRC has 1-cycle latency. o_copro_read_data holds its value while stall is high.
- Read-after-write to the same register in consecutive non-stalled cycles returns the new value.
- The FIFO push is visible at crn 6/7 reads 1 cycle later. Pop likewise.
- Flush of N lines with ack held high takes N cycles in FLUSH. o_flush_busy rises the cycle after the MCR.
- i_flush_ack while o_flush_req is low is ignored.
- i_rst asserted mid-flush: IDLE the next cycle and req low. The FIFO is cleared.

## Structure
- Shared a23 package holds:
  - crn constants (CRN_ID=0, CRN_FLUSH=1, CRN_CTRL=2 … CRN_FLUSH_STAT=8);
  - op codes (OP_MRC=1, OP_MCR=2);
  - the flush state enum {IDLE, FLUSH}.
- One sub-module, a23_fault_fifo: a 40-bit wide FIFO with FAULT_DEPTH entries, count output, and full/empty flags. It uses a pointer-plus-count scheme.
- The flush FSM and register file stay in the top level.

## Test plan
- Reset, then MRC crn 0 → 32'h4156_0310. Then MRC crn 2 → 0. Check o_cache_enable=0 and o_flush_req=0.
- MCR crn 3 = 32'hA5A5_0001, then MRC crn 3 → 32'hA5A5_0001. Repeat with stall high during the MCR: the write is not taken.
- Push 5 faults (status 1..5, addr 0x100..0x500) with depth 4:
  - crn 6 → 32'h8004_0001, crn 7 → 0x100.
  - Pop, then crn 6 → 32'h0003_0002.
- CACHE_LINES=8 with ack held high: MCR crn 1 → busy for exactly 8 cycles, indices 0..7, then IDLE. With ack every other cycle → 16 cycles.
- Mid-flush at index 5: issue MCR crn 1 together with an ack → index 0 next cycle. Assert i_rst at index 3 → req low and index 0 the next cycle.
- Simultaneous pop and push on a full FIFO: count stays 4 and overflow stays 0.
